// File: rtl/usrt_tx_ctrl.sv
// ---------------------------------------------------------------------------
// usrt_tx_ctrl
//
// Transmit controller for a synchronous serial (USRT) link. It takes a byte
// from a tx data register (i_Busy = register holds a byte), serialises it as
// START(0), 8 data bits LSB first, optional even parity bit and STOP(1), and
// produces a serial clock whose single rising edge falls in the middle of
// every bit.
//
// Configuration macro:
//   USRT_TX_PARITY_EN - when defined, an even-parity bit is sent between the
//                       last data bit and the stop bit (11-bit frame).
//                       Undefined (default): 10-bit frame, no parity.
//
// Parameters:
//   CLKS_PER_BIT - i_Pclk cycles per serial bit (even, >= 2), default 4.
//
// Ports:
//   i_Pclk    in   clock, all state changes on its rising edge
//   i_Reset_n in   asynchronous active-low reset
//   i_Enable  in   transmitter enable, gates the start of new frames only
//   i_Busy    in   tx data register holds a valid byte
//   i_Data    in   [7:0] byte from the tx data register
//   o_Done    out  one-cycle pulse in the first START cycle, frees the register
//   o_Sclk    out  serial clock (idles high)
//   o_Tx      out  serial data line (idles high)
//   o_Active  out  high while a frame is in progress
// ---------------------------------------------------------------------------
module usrt_tx_ctrl #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       i_Pclk,
    input  logic       i_Reset_n,
    input  logic       i_Enable,
    input  logic       i_Busy,
    input  logic [7:0] i_Data,
    output logic       o_Done,
    output logic       o_Sclk,
    output logic       o_Tx,
    output logic       o_Active
);

    // Bit counter is wide enough to hold CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef USRT_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           r_State;
    logic [CNT_W-1:0] r_Bit_Cnt;
    logic [2:0]       r_Bit_Idx;
    logic [7:0]       r_Shift;

    logic             w_Cnt_Last;
    logic [CNT_W-1:0] w_Cnt_Inc;
    logic             w_Start_Ok;

    // Helper terms shared by every frame state. w_Cnt_Inc is only used when
    // the counter is not on its last value, so it never wraps.
    always_comb begin
        w_Cnt_Last = (r_Bit_Cnt == CNT_LAST);
        w_Cnt_Inc  = r_Bit_Cnt + 1'b1;
        w_Start_Ok = i_Enable & i_Busy;
    end

    // Single FSM block. All outputs are registered: every assignment below
    // sets the output value that belongs to the state/counter being entered,
    // so the outputs line up cycle-for-cycle with r_State and r_Bit_Cnt.
    // A capture (from IDLE or from the last STOP cycle) loads the byte,
    // pulses o_Done for the first START cycle and drives the start bit.
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State   <= IDLE;
            r_Bit_Cnt <= '0;
            r_Bit_Idx <= '0;
            r_Shift   <= '0;
            o_Tx      <= 1'b1;
            o_Sclk    <= 1'b1;
            o_Done    <= 1'b0;
            o_Active  <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            if ((r_State != IDLE) && !w_Cnt_Last) begin
                // Still inside the current bit: advance the counter and
                // raise the serial clock for the second half of the bit.
                r_Bit_Cnt <= w_Cnt_Inc;
                o_Sclk    <= (w_Cnt_Inc >= CNT_HALF);
            end else begin
                // Bit boundary (or idle): counter restarts and the next bit
                // begins with the serial clock low.
                r_Bit_Cnt <= '0;
                o_Sclk    <= 1'b0;
                case (r_State)
                    IDLE: begin
                        if (w_Start_Ok) begin
                            r_State   <= START;
                            r_Shift   <= i_Data;
                            r_Bit_Idx <= '0;
                            o_Done    <= 1'b1;
                            o_Tx      <= 1'b0;
                            o_Active  <= 1'b1;
                        end else begin
                            o_Sclk    <= 1'b1;
                            o_Tx      <= 1'b1;
                            o_Active  <= 1'b0;
                        end
                    end

                    START: begin
                        r_State   <= DATA;
                        r_Bit_Idx <= '0;
                        o_Tx      <= r_Shift[0];
                    end

                    DATA: begin
                        if (r_Bit_Idx == 3'd7) begin
`ifdef USRT_TX_PARITY_EN
                            r_State <= PARITY;
                            o_Tx    <= ^r_Shift;
`else
                            r_State <= STOP;
                            o_Tx    <= 1'b1;
`endif
                        end else begin
                            r_Bit_Idx <= r_Bit_Idx + 3'd1;
                            o_Tx      <= r_Shift[r_Bit_Idx + 3'd1];
                        end
                    end

`ifdef USRT_TX_PARITY_EN
                    PARITY: begin
                        r_State <= STOP;
                        o_Tx    <= 1'b1;
                    end
`endif

                    STOP: begin
                        // Back-to-back frames: a waiting byte goes straight
                        // into the next START with no idle cycle between.
                        if (w_Start_Ok) begin
                            r_State   <= START;
                            r_Shift   <= i_Data;
                            r_Bit_Idx <= '0;
                            o_Done    <= 1'b1;
                            o_Tx      <= 1'b0;
                            o_Active  <= 1'b1;
                        end else begin
                            r_State   <= IDLE;
                            o_Sclk    <= 1'b1;
                            o_Tx      <= 1'b1;
                            o_Active  <= 1'b0;
                        end
                    end

                    default: begin
                        r_State  <= IDLE;
                        o_Sclk   <= 1'b1;
                        o_Tx     <= 1'b1;
                        o_Active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/usrt_tx_ctrl.md
USRT_TX_CTRL -- requirements
Module: usrt_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, giving i_Pclk cycles per serial bit; legal values are even and >= 2.
REQ-002 SHALL have port i_Pclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_Enable, input, 1 bit: transmitter enable, which gates the start of new frames.
REQ-005 SHALL have port i_Busy, input, 1 bit: the tx data register holds a byte (valid).
REQ-006 SHALL have port i_Data, input, 8 bits: byte from the tx data register.
REQ-007 SHALL have port o_Done, output, 1 bit: single-cycle pulse that releases the tx data register.
REQ-008 SHALL have port o_Sclk, output, 1 bit: serial clock.
REQ-009 SHALL have port o_Tx, output, 1 bit: serial data line.
REQ-010 SHALL have port o_Active, output, 1 bit: high while a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-012 SHALL, in IDLE, when i_Enable=1 and i_Busy=1 at a rising edge, capture i_Data into the shift register and enter START at that edge.
REQ-013 SHALL pulse o_Done high for exactly one cycle: the first cycle of START.
REQ-014 SHALL hold each of START, every DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles, timed by a bit counter from 0 to CLKS_PER_BIT-1.
REQ-015 SHALL drive o_Tx as follows: 1 in IDLE, 0 in START, data bits LSB first in DATA (8 bits, via a 3-bit index), 1 in STOP.
REQ-016 SHALL drive o_Sclk = 1 in IDLE; in any frame state, o_Sclk = 0 while the bit counter < CLKS_PER_BIT/2 and 1 otherwise, giving one rising edge mid-bit.
REQ-017 SHALL drive o_Active = 1 in every state except IDLE.
REQ-018 SHALL, on the last cycle of STOP, go directly to START (capturing i_Data, with no idle cycle) if i_Enable=1 and i_Busy=1; otherwise SHALL go to IDLE.
REQ-019 SHALL let an in-progress frame complete when i_Enable deasserts mid-frame; deassertion only blocks the next capture.
REQ-020 SHALL ignore i_Data and i_Busy changes after capture; the frame uses the captured byte only.
REQ-021 SHALL never assert o_Done outside the first cycle of START, including while i_Busy=1 and i_Enable=0.

Reset
REQ-022 SHALL, while i_Reset_n=0, force asynchronously: state=IDLE, counters=0, shift register=0, o_Tx=1, o_Sclk=1, o_Done=0, o_Active=0.
REQ-023 SHALL, when reset asserts mid-frame, abort the frame immediately with no o_Done pulse and no stop bit.
REQ-024 SHALL be able to capture a byte on the first rising edge after i_Reset_n deasserts.

Configuration
REQ-025 SHALL, when macro USRT_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP. In PARITY, o_Tx = XOR of the 8 captured bits (even parity), and the frame is 11 bits.
REQ-026 SHALL, when USRT_TX_PARITY_EN is undefined, have no PARITY state. DATA goes directly to STOP and the frame is 10 bits.

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL cover basic frame: after reset, i_Enable=1, i_Busy=1, i_Data=0x53 -> o_Tx bits 0,1,1,0,0,1,0,1,0,1, each 4 cycles; o_Done pulses once, in START cycle 1; o_Active high for 40 cycles.
REQ-028 SHALL cover parity: with USRT_TX_PARITY_EN defined, 0x53 -> parity bit 0, and 0xE6 -> parity bit 1; frames are 44 cycles.
REQ-029 SHALL cover back-to-back frames: i_Busy kept 1 with 0x53 then 0xE6 -> the STOP of frame 1 is followed immediately by the START of frame 2, with no idle cycle; exactly two o_Done pulses.
REQ-030 SHALL cover enable gating: i_Enable=0, i_Busy=1 -> o_Tx=1, o_Sclk=1, o_Done never asserts; raising i_Enable starts the frame on the next edge.
REQ-031 SHALL cover mid-frame enable drop: i_Enable dropped during DATA bit 3 of 0x0E -> the frame completes through STOP, then the block stays IDLE.
REQ-032 SHALL cover mid-frame reset: i_Reset_n pulsed low during DATA -> o_Tx=1, o_Sclk=1, o_Active=0 immediately, and no o_Done; the next frame after release is correct.
